stepper_step_sequencer: RTL

//  Downstream consumer of the ASIP ALU result: a byte written to the motor command port.

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_step_sequencer_step_timer.sv | 30 +++
 rtl/stepper_step_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared stepper definitions: FSM encodings, coil phase table and command byte layout.
// Also used by the ASIP output-port decode.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } step_state_t;

    localparam int CMD_DIR_BIT = 7;
    localparam int CMD_CNT_MSB = 6;

    // Index 0 is the leftmost entry; half-step sequence for a 4-wire stepper.
    localparam logic [0:7][3:0] PHASE_TABLE = {
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    function automatic logic [3:0] phase_of(input logic coil_en, input logic [2:0] idx);
        return coil_en ? PHASE_TABLE[idx] : 4'b0000;
    endfunction

endpackage

// File: rtl/stepper_step_sequencer_step_timer.sv
// Loadable down-counter: ticks when it reaches zero while enabled, then reloads itself.
module step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    input  logic                en,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] rld;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            rld <= '0;
        end else if (load) begin
            cnt <= load_val;
            rld <= load_val;
        end else if (en) begin
            cnt <= (cnt == '0) ? rld : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/stepper_step_sequencer.sv
// Command-driven stepper sequencer: turns a dir/count byte into timed coil phase steps
// and tracks a wrapping signed position.
module stepper_step_sequencer
    import stepper_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    output logic                cmd_ready,
    input  logic [PERIOD_W-1:0] period,
    input  logic                half_step,
    input  logic                abort,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                done,
    output logic [7:0]          pos
);

    step_state_t state, state_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  pos_n;
    logic [6:0]  remaining, remaining_n;
    logic        dir, dir_n;
    logic        half, half_n;
    logic        coil_en, coil_en_n;
    logic        busy_n;
    logic        accept, tick, timer_en;
    logic [PERIOD_W-1:0] p_m1;

    assign cmd_ready = (state == ST_IDLE);
    assign done      = (state == ST_FIN);
    assign accept    = cmd_valid && cmd_ready;
    assign timer_en  = (state == ST_RUN);
    // A zero period behaves as one clock per step.
    assign p_m1      = (period == '0) ? '0 : period - 1'b1;

    step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (p_m1),
        .en       (timer_en),
        .tick     (tick)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        pos_n       = pos;
        remaining_n = remaining;
        dir_n       = dir;
        half_n      = half;
        coil_en_n   = coil_en;
        busy_n      = busy;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    dir_n       = cmd_data[CMD_DIR_BIT];
                    remaining_n = cmd_data[CMD_CNT_MSB:0];
                    half_n      = half_step;
                    coil_en_n   = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = (cmd_data[CMD_CNT_MSB:0] == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort beats a step landing on the same edge.
                if (abort) begin
                    state_n = ST_FIN;
                end else if (tick) begin
                    idx_n       = dir ? idx - (half ? 3'd1 : 3'd2) : idx + (half ? 3'd1 : 3'd2);
                    pos_n       = dir ? pos - 8'd1 : pos + 8'd1;
                    remaining_n = remaining - 7'd1;
                    if (remaining == 7'd1) state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            pos       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            half      <= 1'b0;
            coil_en   <= 1'b0;
            busy      <= 1'b0;
            phase     <= 4'b0000;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pos       <= pos_n;
            remaining <= remaining_n;
            dir       <= dir_n;
            half      <= half_n;
            coil_en   <= coil_en_n;
            busy      <= busy_n;
            phase     <= phase_of(coil_en_n, idx_n);
        end
    end

endmodule
